// File: rtl/fila_pkg.sv
// Shared types and sizes for the queue front-end controller.
//   fila_ctrl_state_t : controller FSM states
//   FILA_DEPTH        : queue capacity in words
//   FILA_WIDTH        : data word width
//   FILA_LEN_W        : width of the queue occupancy bus
package fila_pkg;

    localparam int unsigned FILA_DEPTH = 8;
    localparam int unsigned FILA_WIDTH = 8;
    localparam int unsigned FILA_LEN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENQ      = 3'd1,
        ST_DEQ      = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_WAIT_REL = 3'd4
    } fila_ctrl_state_t;

endpackage

// File: rtl/fila_ctrl_if.sv
// Controller <-> queue bus.
//   enqueue_out / dequeue_out : one-cycle request pulses to the queue
//   data_out                  : word presented to the queue data_in
//   q_len / q_data            : queue occupancy and output word
// master = controller side, slave = queue side.
interface fila_ctrl_if
    import fila_pkg::*;
#(
    parameter int unsigned WIDTH = FILA_WIDTH
) ();

    logic                  enqueue_out;
    logic                  dequeue_out;
    logic [WIDTH-1:0]      data_out;
    logic [FILA_LEN_W-1:0] q_len;
    logic [WIDTH-1:0]      q_data;

    modport master (
        output enqueue_out,
        output dequeue_out,
        output data_out,
        input  q_len,
        input  q_data
    );

    modport slave (
        input  enqueue_out,
        input  dequeue_out,
        input  data_out,
        output q_len,
        output q_data
    );

endinterface

// File: rtl/fila_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce, rising-edge
// detector producing one press strobe per physical press.
// Debounce is built only when FILA_CTRL_DEBOUNCE_EN is defined.
//   clk_10KHz, reset : clock, async active-high reset
//   btn              : raw asynchronous button
//   level            : conditioned button level
//   press            : registered one-cycle strobe on a conditioned rising edge
module fila_btn_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk_10KHz,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       press_q;
    logic       armed_q;
    logic [1:0] fill_q;
    logic       level_c;

`ifdef FILA_CTRL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Level follows the synchronizer only after DEBOUNCE_CYCLES straight disagreeing cycles.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign level_c = level_q;
`else
    assign level_c = sync2_q;
`endif

    // armed_q only sets once the filled synchronizer has seen the button low,
    // so a button held through reset release cannot produce a press.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
            prev_q  <= level_c;
            press_q <= armed_q & level_c & ~prev_q;
        end
    end

    assign level = level_c;
    assign press = press_q;

endmodule

// File: rtl/fila_ctrl.sv
// Queue front-end controller: turns button presses into single-cycle
// enqueue/dequeue pulses, blocks overflow/underflow, captures dequeued words.
// Optional button debounce: define FILA_CTRL_DEBOUNCE_EN.
//   clk_10KHz, reset  : clock, async active-high reset
//   btn_enq, btn_deq  : raw push-buttons
//   sw_data           : word to enqueue
//   q                 : queue bus (master side)
//   last_deq          : last word removed from the queue
//   full, empty       : combinational status from q.q_len
//   err               : sticky, last press was rejected
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int unsigned WIDTH           = FILA_WIDTH,
    parameter int unsigned DEPTH           = FILA_DEPTH,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             btn_enq,
    input  logic             btn_deq,
    input  logic [WIDTH-1:0] sw_data,
    fila_ctrl_if.master      q,
    output logic [WIDTH-1:0] last_deq,
    output logic             full,
    output logic             empty,
    output logic             err
);

    fila_ctrl_state_t state_q;
    logic             enq_q;
    logic             deq_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] last_deq_q;
    logic             err_q;

    logic enq_level;
    logic enq_press;
    logic deq_level;
    logic deq_press;

    fila_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enq_btn (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .btn       (btn_enq),
        .level     (enq_level),
        .press     (enq_press)
    );

    fila_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deq_btn (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .btn       (btn_deq),
        .level     (deq_level),
        .press     (deq_press)
    );

    // Occupancy above DEPTH is treated as full.
    assign full  = 32'(q.q_len) >= DEPTH;
    assign empty = q.q_len == '0;

    // Controller FSM; enqueue press has priority over a same-cycle dequeue press.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            enq_q      <= 1'b0;
            deq_q      <= 1'b0;
            data_q     <= '0;
            last_deq_q <= '0;
            err_q      <= 1'b0;
        end else begin
            enq_q <= 1'b0;
            deq_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (enq_press) begin
                        if (!full) begin
                            state_q <= ST_ENQ;
                            enq_q   <= 1'b1;
                            data_q  <= sw_data;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT_REL;
                            err_q   <= 1'b1;
                        end
                    end else if (deq_press) begin
                        if (!empty) begin
                            state_q <= ST_DEQ;
                            deq_q   <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_WAIT_REL;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ENQ:     state_q <= ST_WAIT_REL;
                ST_DEQ:     state_q <= ST_CAPTURE;
                ST_CAPTURE: begin
                    // Queue updated q_data on the edge that sampled the dequeue pulse.
                    last_deq_q <= q.q_data;
                    state_q    <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!enq_level && !deq_level) begin
                        state_q <= ST_IDLE;
                    end
                end
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign q.enqueue_out = enq_q;
    assign q.dequeue_out = deq_q;
    assign q.data_out    = data_q;
    assign last_deq      = last_deq_q;
    assign err           = err_q;

endmodule

// File: tb/tb_fila_ctrl.sv
// Self-checking bench for fila_ctrl: reset, latency, directed vector table,
// reset corner cases, and randomized presses against a queue-level model.
module tb_fila_ctrl;
    import fila_pkg::*;

`ifdef FILA_CTRL_DEBOUNCE_EN
    localparam int DB = 20;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 4 + DB;

    logic       clk_10KHz = 1'b0;
    logic       reset     = 1'b1;
    logic       btn_enq   = 1'b0;
    logic       btn_deq   = 1'b0;
    logic [7:0] sw_data   = 8'h00;
    logic [7:0] last_deq;
    logic       full;
    logic       empty;
    logic       err;

    fila_ctrl_if #(.WIDTH(8)) q_if ();

    fila_ctrl #(.WIDTH(8), .DEPTH(8), .DEBOUNCE_CYCLES(20)) dut (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .btn_enq   (btn_enq),
        .btn_deq   (btn_deq),
        .sw_data   (sw_data),
        .q         (q_if),
        .last_deq  (last_deq),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #50 clk_10KHz = ~clk_10KHz;

    int n_chk  = 0;
    int n_pass = 0;
    int tot_enq = 0;
    int tot_deq = 0;
    int viol    = 0;
    bit prev_e  = 1'b0;
    bit prev_d  = 1'b0;

    // Queue environment: directed values when env_en=0, behavioural 8-deep queue otherwise.
    bit         env_en    = 1'b0;
    logic [7:0] tb_len    = 8'd0;
    logic [7:0] tb_qdata  = 8'h00;
    logic [7:0] env_len   = 8'd0;
    logic [7:0] env_qdata = 8'h00;
    logic [7:0] env_q[$];

    assign q_if.q_len  = env_en ? env_len   : tb_len;
    assign q_if.q_data = env_en ? env_qdata : tb_qdata;

    always @(negedge clk_10KHz) begin
        if (q_if.enqueue_out) tot_enq++;
        if (q_if.dequeue_out) tot_deq++;
        if (q_if.enqueue_out && q_if.dequeue_out) viol++;
        if ((q_if.enqueue_out && prev_e) || (q_if.dequeue_out && prev_d)) viol++;
        prev_e = q_if.enqueue_out;
        prev_d = q_if.dequeue_out;
        if (env_en) begin
            if (q_if.enqueue_out && env_q.size() < 8) env_q.push_back(q_if.data_out);
            if (q_if.dequeue_out && env_q.size() > 0) env_qdata = env_q.pop_front();
            env_len = 8'(env_q.size());
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, exp);
    endtask

    // Press the given buttons long enough for one pulse, release, let FSM return to IDLE.
    task automatic do_op(input bit e, input bit d, input logic [7:0] sw);
        @(negedge clk_10KHz);
        sw_data = sw;
        btn_enq = e;
        btn_deq = d;
        repeat (LAT + 4) @(negedge clk_10KHz);
        btn_enq = 1'b0;
        btn_deq = 1'b0;
        repeat (LAT + 6) @(negedge clk_10KHz);
    endtask

    typedef struct {
        bit         e;
        bit         d;
        logic [7:0] sw;
        logic [7:0] len;
        logic [7:0] qd;
        int         n_enq;
        int         n_deq;
        bit         x_err;
        logic [7:0] x_last;
        logic [7:0] x_data;
        bit         x_full;
        bit         x_empty;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int         e0;
        int         d0;
        int         lat;
        bit         found;
        bit         e;
        bit         d;
        int         r;
        logic [7:0] sw;
        logic [7:0] rq[$];
        bit         x_err;
        logic [7:0] x_last;
        logic [7:0] x_data;
        int         ne;
        int         nd;

        //           e d  sw     len   qd     #e #d err last   data   full empty
        tbl[0] = '{1, 0, 8'hA5, 8'd0, 8'h00, 1, 0, 0, 8'h00, 8'hA5, 0, 1};
        tbl[1] = '{0, 1, 8'hFF, 8'd3, 8'h3C, 0, 1, 0, 8'h3C, 8'hA5, 0, 0};
        tbl[2] = '{1, 0, 8'h11, 8'd8, 8'h3C, 0, 0, 1, 8'h3C, 8'hA5, 1, 0};
        tbl[3] = '{0, 1, 8'h22, 8'd8, 8'h77, 0, 1, 0, 8'h77, 8'hA5, 1, 0};
        tbl[4] = '{0, 1, 8'h33, 8'd0, 8'h99, 0, 0, 1, 8'h77, 8'hA5, 0, 1};
        tbl[5] = '{1, 1, 8'h5A, 8'd2, 8'h44, 1, 0, 0, 8'h77, 8'h5A, 0, 0};
        tbl[6] = '{1, 0, 8'h66, 8'd9, 8'h00, 0, 0, 1, 8'h77, 8'h5A, 1, 0};
        tbl[7] = '{1, 0, 8'hC3, 8'd7, 8'h00, 1, 0, 0, 8'h77, 8'hC3, 0, 0};

        // Reset state
        #1;
        chk("rst_enqueue_out", q_if.enqueue_out, 0);
        chk("rst_dequeue_out", q_if.dequeue_out, 0);
        chk("rst_data_out", q_if.data_out, 0);
        chk("rst_last_deq", last_deq, 0);
        chk("rst_err", err, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        repeat (3) @(negedge clk_10KHz);
        reset = 1'b0;
        repeat (5) @(negedge clk_10KHz);

        // Press-to-pulse latency and pulse width
        @(negedge clk_10KHz);
        btn_enq = 1'b1;
        lat = 0;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(negedge clk_10KHz);
            if (q_if.enqueue_out) begin
                lat = i;
                break;
            end
        end
        chk("enq_latency", lat, LAT);
        @(negedge clk_10KHz);
        chk("enq_pulse_width", q_if.enqueue_out, 0);
        btn_enq = 1'b0;
        repeat (LAT + 6) @(negedge clk_10KHz);

        // Button held through reset release: no press until released and re-pressed
        e0 = tot_enq;
        reset   = 1'b1;
        btn_enq = 1'b1;
        repeat (3) @(negedge clk_10KHz);
        reset = 1'b0;
        repeat (LAT + 20) @(negedge clk_10KHz);
        chk("held_through_reset_no_press", tot_enq - e0, 0);
        btn_enq = 1'b0;
        repeat (LAT + 6) @(negedge clk_10KHz);
        do_op(1'b1, 1'b0, 8'h00);
        chk("held_through_reset_repress", tot_enq - e0, 1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            tb_len   = tbl[i].len;
            tb_qdata = tbl[i].qd;
            e0 = tot_enq;
            d0 = tot_deq;
            do_op(tbl[i].e, tbl[i].d, tbl[i].sw);
            chk($sformatf("vec%0d_enq_pulses", i), tot_enq - e0, tbl[i].n_enq);
            chk($sformatf("vec%0d_deq_pulses", i), tot_deq - d0, tbl[i].n_deq);
            chk($sformatf("vec%0d_err", i), err, tbl[i].x_err);
            chk($sformatf("vec%0d_last_deq", i), last_deq, tbl[i].x_last);
            chk($sformatf("vec%0d_data_out", i), q_if.data_out, tbl[i].x_data);
            chk($sformatf("vec%0d_full", i), full, tbl[i].x_full);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].x_empty);
        end

        // Reset asserted while enqueue_out is high
        tb_len = 8'd0;
        @(negedge clk_10KHz);
        sw_data = 8'h5F;
        btn_enq = 1'b1;
        found = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clk_10KHz);
            if (q_if.enqueue_out) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_pulse_seen", found, 1);
        reset = 1'b1;
        #1;
        chk("mid_pulse_rst_enqueue_out", q_if.enqueue_out, 0);
        chk("mid_pulse_rst_dequeue_out", q_if.dequeue_out, 0);
        chk("mid_pulse_rst_data_out", q_if.data_out, 0);
        chk("mid_pulse_rst_last_deq", last_deq, 0);
        chk("mid_pulse_rst_err", err, 0);
        btn_enq = 1'b0;
        repeat (3) @(negedge clk_10KHz);
        reset = 1'b0;
        repeat (LAT + 6) @(negedge clk_10KHz);

`ifdef FILA_CTRL_DEBOUNCE_EN
        // Short glitches are filtered; a long hold gives exactly one pulse
        e0 = tot_enq;
        for (int i = 0; i < 3; i++) begin
            btn_enq = 1'b1;
            repeat (5) @(negedge clk_10KHz);
            btn_enq = 1'b0;
            repeat (5) @(negedge clk_10KHz);
        end
        repeat (30) @(negedge clk_10KHz);
        chk("glitch_no_pulse", tot_enq - e0, 0);
        btn_enq = 1'b1;
        repeat (25) @(negedge clk_10KHz);
        btn_enq = 1'b0;
        repeat (40) @(negedge clk_10KHz);
        chk("hold25_one_pulse", tot_enq - e0, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk_10KHz);
        reset = 1'b0;
        repeat (5) @(negedge clk_10KHz);
`endif

        // Randomized presses against a queue-level reference model
        env_q.delete();
        env_len   = 8'd0;
        env_qdata = 8'h00;
        env_en    = 1'b1;
        x_err  = 1'b0;
        x_last = 8'h00;
        x_data = 8'h00;
        for (int k = 0; k < 40; k++) begin
            r  = int'($urandom_range(0, 9));
            e  = (r < 6) || (r == 9);
            d  = (r >= 6);
            sw = 8'($urandom);
            ne = 0;
            nd = 0;
            if (e) begin
                if (rq.size() >= 8) x_err = 1'b1;
                else begin
                    rq.push_back(sw);
                    x_data = sw;
                    x_err  = 1'b0;
                    ne     = 1;
                end
            end else begin
                if (rq.size() == 0) x_err = 1'b1;
                else begin
                    x_last = rq.pop_front();
                    x_err  = 1'b0;
                    nd     = 1;
                end
            end
            e0 = tot_enq;
            d0 = tot_deq;
            do_op(e, d, sw);
            chk($sformatf("rnd%0d_enq_pulses", k), tot_enq - e0, ne);
            chk($sformatf("rnd%0d_deq_pulses", k), tot_deq - d0, nd);
            chk($sformatf("rnd%0d_err", k), err, x_err);
            chk($sformatf("rnd%0d_last_deq", k), last_deq, x_last);
            chk($sformatf("rnd%0d_data_out", k), q_if.data_out, x_data);
            chk($sformatf("rnd%0d_full", k), full, rq.size() >= 8);
            chk($sformatf("rnd%0d_empty", k), empty, rq.size() == 0);
        end

        chk("pulse_overlap_or_repeat", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
